interpol_feed: RTL and testbench
================================

// Module: interpol_feed
// PURPOSE
//  Source end of the interpol link: decimates a per-cycle signed sample stream x into the sparse
//  (strobe, dy, dy7) triple that interpol consumes. Every PERIOD cycles it captures x, forms
//  dy = x_now - x_prev and dy7 = dy*2^CNTW/PERIOD, then pulses strobe with dy and dy7 valid in the same cycle.
//  Sits upstream of interpol, e.g. a slow-loop setpoint path whose output is smoothed back to clk rate.
// PARAMETERS
//  CNTW    7      counter width; the downstream interpol shares the same CNTW
//  PERIOD  112    decimation ratio in clk cycles; legal range 2^(CNTW-1) < PERIOD <= 2^CNTW
//  SCALE   74898  unsigned Q1.16 factor, round(65536*2^CNTW/PERIOD); must match PERIOD
// PORTS
//  clk           in   1   sole clock, all logic on posedge
//  rst_n         in   1   asynchronous, active-low reset
//  x             in   17  signed sample, read every cycle
//  sync          in   1   external alignment pulse: forces a capture this cycle
//  sync_err_clr  in   1   clears sync_err
//  strobe        out  1   one-cycle pulse; dy/dy7 are valid and updated in this cycle
//  dy            out  17  signed saturated difference; held between strobes
//  dy7           out  18  signed, rounded and saturated dy*SCALE/2^16; held between strobes
//  sat           out  1   high with strobe when dy or dy7 saturated
//  sync_err      out  1   sticky; set when sync arrives with ccnt != 0
// BEHAVIOUR
//  Reset (async assert, sync release): ccnt = PERIOD-1, primed = 0, pipeline valids = 0.
//   All outputs are 0. Reset mid-pipeline discards any in-flight capture.
//  Counter: ccnt decrements every clk. The capture cycle C is any cycle with ccnt==0 or sync==1.
//   At C, ccnt reloads PERIOD-1.
//  sync with ccnt != 0: capture still happens at C and sync_err <= 1.
//   sync with ccnt == 0: no error (already aligned).
//  sync_err_clr in the same cycle as a new error: the set wins.
//  Pipeline (edge E0 = the edge ending cycle C):
//   E0:   xs <= x; xp <= xs; v1 <= primed; primed <= 1
//   E0+1: d18 = xs - xp (18b exact); dyr <= sat17(d18); s1 <= overflow; v2 <= v1
//   E0+2: p <= dyr * SCALE (35b signed); v3 <= v2
//   E0+3: dy <= dyr; dy7 <= sat18((p + 2^15) >>> 16); sat <= s1 | dy7_ovf; strobe <= v3
//  dy, dy7 and sat are written only when v3 == 1. sat and strobe fall to 0 the next cycle.
//  Latency: x sampled at E0 -> strobe high in the cycle after edge E0+3.
//  The first capture after reset only primes xp; it produces no strobe.
//  sat17 clamps to [-65536, 65535]; sat18 clamps to [-131072, 131071].
//   Rounding is half-up (add 2^15, then arithmetic shift).
//  Captures less than 3 cycles apart, caused by sync, are all processed; each yields its own strobe, in order.
// STRUCTURE
//  Shared package interpol_pkg: DY_W=17, DY7_W=18, Q=16, and a constant function
//   scale_for(cntw, period) for SCALE. The interpol block uses the same package.
//  One natural sub-module: interpol_sat_round_mult. It holds the E0+2..E0+3 stages:
//   multiply, round and saturate, with a valid in and a valid out.
//  The top level holds the counter, sync/err logic, capture and the difference stage.
// TESTING
//  1 Constant x=1000 from reset: no strobe at the first capture. Then a strobe every 112 cycles with dy=0, dy7=0, sat=0.
//  2 Step: x=0 until one capture, then x=1120: the next strobe has dy=1120, dy7=1280. The following strobe has dy=0.
//  3 Negative: x steps 500 -> 388: dy=-112, dy7=-128, sat=0.
//  4 Saturation: x=-65536, then 65535: dy=65535, dy7=74897, sat=1 only in the strobe cycle.
//  5 Sync at ccnt=50: capture at that cycle, sync_err=1.
//    Next capture is 112 cycles later. sync_err_clr -> 0. A sync at ccnt==0 leaves sync_err at 0.
//  6 rst_n low 1 cycle after a capture: no strobe, outputs 0, and the first capture after release is priming only.
//  All: check strobe spacing == PERIOD and that dy/dy7 change only on strobe edges.

Source files
------------

// File: rtl/interpol_pkg.sv
// Shared widths and scale helper for the interpol link (feed and interpol consume the same package).
package interpol_pkg;
  localparam int DY_W  = 17;
  localparam int DY7_W = 18;
  localparam int Q     = 16;
  localparam int P_W   = DY_W + DY7_W;

  // round(2^Q * 2^cntw / period), the Q1.16 factor turning a per-period step into a per-2^cntw step
  function automatic int scale_for(input int cntw, input int period);
    longint num;
    num = longint'(1) << (Q + cntw);
    return int'((num + longint'(period / 2)) / longint'(period));
  endfunction
endpackage

// File: rtl/interpol_sat_round_mult.sv
// Back end of the feed pipeline: dy*SCALE, half-up rounding to Q0, 18-bit saturation, output registers.
module interpol_sat_round_mult
  import interpol_pkg::*;
#(
  parameter int SCALE = 74898
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vin,
  input  logic signed [DY_W-1:0]  din,
  input  logic                    sin,
  output logic                    strobe,
  output logic signed [DY_W-1:0]  dy,
  output logic signed [DY7_W-1:0] dy7,
  output logic                    sat
);
  localparam logic signed [DY_W:0]    SC   = $signed(SCALE[DY_W:0]);
  localparam logic signed [P_W-1:0]   HALF = P_W'(1) <<< (Q - 1);
  localparam logic signed [P_W-1:0]   MAX7 = P_W'((1 << (DY7_W - 1)) - 1);
  localparam logic signed [P_W-1:0]   MIN7 = -P_W'(1 << (DY7_W - 1));

  logic                   v3, sq;
  logic signed [DY_W-1:0] dq;
  logic signed [P_W-1:0]  p, r;
  logic                   ovf7;
  logic signed [DY7_W-1:0] dy7_n;

  // dy and its saturation flag travel with the product so back-to-back captures stay paired
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3 <= 1'b0;
      p  <= '0;
      dq <= '0;
      sq <= 1'b0;
    end else begin
      v3 <= vin;
      if (vin) begin
        p  <= P_W'(din) * P_W'(SC);
        dq <= din;
        sq <= sin;
      end
    end
  end

  always_comb begin
    r     = (p + HALF) >>> Q;
    ovf7  = (r > MAX7) || (r < MIN7);
    dy7_n = r[DY7_W-1:0];
    if (ovf7) dy7_n = r[P_W-1] ? MIN7[DY7_W-1:0] : MAX7[DY7_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      strobe <= 1'b0;
      dy     <= '0;
      dy7    <= '0;
      sat    <= 1'b0;
    end else begin
      strobe <= v3;
      if (v3) begin
        dy  <= dq;
        dy7 <= dy7_n;
        sat <= sq | ovf7;
      end else begin
        sat <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/interpol_feed.sv
// Decimating source for interpol: every PERIOD cycles (or on sync) captures x and emits dy / dy7 with a strobe.
module interpol_feed
  import interpol_pkg::*;
#(
  parameter int CNTW   = 7,
  parameter int PERIOD = 112,
  parameter int SCALE  = scale_for(CNTW, PERIOD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [DY_W-1:0]  x,
  input  logic                    sync,
  input  logic                    sync_err_clr,
  output logic                    strobe,
  output logic signed [DY_W-1:0]  dy,
  output logic signed [DY7_W-1:0] dy7,
  output logic                    sat,
  output logic                    sync_err
);
  localparam logic [CNTW-1:0]        RELOAD = CNTW'(PERIOD - 1);
  localparam logic signed [DY_W-1:0] DY_MAX = {1'b0, {(DY_W-1){1'b1}}};
  localparam logic signed [DY_W-1:0] DY_MIN = {1'b1, {(DY_W-1){1'b0}}};

  logic [CNTW-1:0]        ccnt;
  logic                   cap, primed;
  logic [2:1]             vld_pipe;
  logic signed [DY_W-1:0] xs, xp, dyr;
  logic signed [DY_W:0]   d18;
  logic                   ovf, s1;

  assign cap = (ccnt == '0) | sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ccnt     <= RELOAD;
      sync_err <= 1'b0;
    end else begin
      ccnt <= cap ? RELOAD : ccnt - 1'b1;
      // a new error takes priority over a clear in the same cycle
      if (sync && ccnt != '0) sync_err <= 1'b1;
      else if (sync_err_clr)  sync_err <= 1'b0;
    end
  end

  // first capture after reset only loads the history register, hence v1 <= primed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xs       <= '0;
      xp       <= '0;
      primed   <= 1'b0;
      vld_pipe <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], cap & primed};
      if (cap) begin
        xs     <= x;
        xp     <= xs;
        primed <= 1'b1;
      end
    end
  end

  always_comb begin
    d18 = {xs[DY_W-1], xs} - {xp[DY_W-1], xp};
    ovf = d18[DY_W] != d18[DY_W-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dyr <= '0;
      s1  <= 1'b0;
    end else if (vld_pipe[1]) begin
      dyr <= ovf ? (d18[DY_W] ? DY_MIN : DY_MAX) : d18[DY_W-1:0];
      s1  <= ovf;
    end
  end

  interpol_sat_round_mult #(.SCALE(SCALE)) u_srm (
    .clk    (clk),
    .rst_n  (rst_n),
    .vin    (vld_pipe[2]),
    .din    (dyr),
    .sin    (s1),
    .strobe (strobe),
    .dy     (dy),
    .dy7    (dy7),
    .sat    (sat)
  );
endmodule

// File: tb/tb_interpol_feed.sv
// Bench for interpol_feed: table of held x values with expected strobe outputs, scoreboard on strobes.
module tb_interpol_feed;
  localparam int PERIOD = 112;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [16:0] x = '0;
  logic               sync = 1'b0;
  logic               sync_err_clr = 1'b0;
  logic               strobe, sat, sync_err;
  logic signed [16:0] dy;
  logic signed [17:0] dy7;

  interpol_feed dut (
    .clk(clk), .rst_n(rst_n), .x(x), .sync(sync), .sync_err_clr(sync_err_clr),
    .strobe(strobe), .dy(dy), .dy7(dy7), .sat(sat), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [16:0] x;
    logic signed [16:0] dy;
    logic signed [17:0] dy7;
    logic               sat;
  } vec_t;

  typedef struct {
    logic signed [16:0] dy;
    logic signed [17:0] dy7;
    logic               sat;
    int                 cyc;
  } exp_t;

  vec_t vec[12];
  vec_t cur;
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   cap_cnt = 0;
  int   m_ccnt  = PERIOD - 1;
  bit   m_primed = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // capture model: counter, sync, priming; pushes the expected strobe for each real capture
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_ccnt   = PERIOD - 1;
      m_primed = 0;
    end else begin
      cyc++;
      if (m_ccnt == 0 || sync) begin
        if (m_primed) exp_q.push_back('{cur.dy, cur.dy7, cur.sat, cyc + 3});
        m_primed = 1;
        m_ccnt   = PERIOD - 1;
        cap_cnt++;
      end else begin
        m_ccnt--;
      end
    end
  end

  // scoreboard / hold monitor
  initial forever begin
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst_n) continue;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      chk("strobe_missing_at", cyc, e.cyc);
    end
    if (strobe) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got strobe=1 required 0 (cycle %0d)", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("dy", dy, e.dy);
        chk("dy7", dy7, e.dy7);
        chk("sat", sat, e.sat);
      end
    end else begin
      chk("sat_idle", sat, 0);
    end
  end

  // dy/dy7 may only move on a strobe edge (or under reset)
  initial forever begin
    logic signed [16:0] ldy;
    logic signed [17:0] ldy7;
    @(negedge clk);
    ldy = dy; ldy7 = dy7;
    @(posedge clk);
    #1;
    if (rst_n && !strobe) begin
      chk("dy_hold", dy, ldy);
      chk("dy7_hold", dy7, ldy7);
    end
  end

  task automatic wait_cap();
    int c0 = cap_cnt;
    int k  = 0;
    while (cap_cnt == c0 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("capture_seen", cap_cnt != c0, 1);
    @(negedge clk);
  endtask

  task automatic wait_ccnt(input int v);
    int k = 0;
    while (m_ccnt != v && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("ccnt_reached", m_ccnt, v);
  endtask

  initial begin
    vec[0]  = '{1000,       0,       0, 0};  // priming only
    vec[1]  = '{1000,       0,       0, 0};
    vec[2]  = '{1000,       0,       0, 0};
    vec[3]  = '{0,      -1000,   -1143, 0};
    vec[4]  = '{1120,    1120,    1280, 0};
    vec[5]  = '{1120,       0,       0, 0};
    vec[6]  = '{500,     -620,    -709, 0};
    vec[7]  = '{388,     -112,    -128, 0};
    vec[8]  = '{-65536, -65536, -74898, 1};
    vec[9]  = '{65535,   65535,  74897, 1};
    vec[10] = '{65535,       0,      0, 0};
    vec[11] = '{-65536, -65536, -74898, 1};
    cur = vec[0];

    repeat (3) @(negedge clk);
    chk("rst_strobe", strobe, 0);
    chk("rst_dy", dy, 0);
    chk("rst_dy7", dy7, 0);
    chk("rst_sat", sat, 0);
    chk("rst_sync_err", sync_err, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      x = vec[i].x;
      cur = vec[i];
      wait_cap();
    end

    // sync mid-period: capture there, error set, period restarts from it
    cur = '{-65536, 0, 0, 0};
    wait_ccnt(50);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    chk("sync_err_set", sync_err, 1);
    wait_cap();
    sync_err_clr = 1'b1;
    @(negedge clk);
    sync_err_clr = 1'b0;
    chk("sync_err_clr", sync_err, 0);
    wait_ccnt(0);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    chk("sync_aligned_no_err", sync_err, 0);

    // set beats clear
    wait_ccnt(20);
    sync = 1'b1;
    sync_err_clr = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    sync_err_clr = 1'b0;
    chk("sync_err_set_wins", sync_err, 1);

    // back-to-back sync captures each give their own strobe
    x = 0;
    cur = '{0, 65535, 74897, 1};
    wait_cap();
    wait_ccnt(40);
    x = 100;
    cur = '{100, 100, 114, 0};
    sync = 1'b1;
    @(negedge clk);
    x = -100;
    cur = '{-100, -200, -229, 0};
    @(negedge clk);
    sync = 1'b0;
    repeat (6) @(negedge clk);
    chk("b2b_drained", exp_q.size(), 0);

    // reset right after a capture discards it; next capture only primes
    x = 5000;
    cur = '{5000, 5100, 5829, 0};
    wait_cap();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst2_strobe", strobe, 0);
    chk("rst2_dy", dy, 0);
    chk("rst2_dy7", dy7, 0);
    chk("rst2_sat", sat, 0);
    chk("rst2_sync_err", sync_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    x = 6000;
    cur = '{6000, 0, 0, 0};
    wait_cap();
    x = 6112;
    cur = '{6112, 112, 128, 0};
    wait_cap();

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
